// File: rtl/galois_lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : galois_lfsr_checker                                           |
// | Purpose  : Receive-side checker for a Galois LFSR test pattern. Seeds    |
// |            from the incoming state words and confirms a run of correct   |
// |            predictions before declaring lock. While locked it flywheels  |
// |            the expected sequence and counts mismatching words.           |
// | Ports    : clk         - system clock, rising edge                       |
// |            arst_n      - asynchronous active-low reset                   |
// |            in_valid    - in_data is sampled this cycle                   |
// |            in_data     - received LFSR state word [BITWIDTH-1:0]         |
// |            clr_cnt     - synchronous clear of the error counter(s)       |
// |            locked      - checker is synchronised                         |
// |            err_pulse   - one-cycle flag, mismatching sample while locked |
// |            err_cnt     - saturating mismatch count [CNT_W-1:0]           |
// |            zero_det    - one-cycle flag, all-zero (lockup) sample        |
// |            bit_err_cnt - saturating bit-error count (optional)           |
// | Option   : define LFSR_CHK_BITERR_EN to add bit_err_cnt.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module galois_lfsr_checker #(
  parameter int                  BITWIDTH    = 5,
  parameter logic [BITWIDTH-1:0] TAPS        = 5'b10100,
  parameter int                  LOCK_CNT    = 4,
  parameter int                  UNLOCK_ERRS = 3,
  parameter int                  CNT_W       = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                clr_cnt,
  output logic                locked,
  output logic                err_pulse,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                zero_det
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0]    bit_err_cnt
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [BITWIDTH-1:0] nxt(input logic [BITWIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  state_t               state_q, state_d;
  logic [BITWIDTH-1:0]  expected_q, expected_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]    miss_run_q, miss_run_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 zero_det_q, zero_det_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]     err_base;
  logic                 err_hit;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_run_d  = miss_run_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    zero_det_d  = 1'b0;
    err_hit     = 1'b0;

    if (in_valid) begin
      zero_det_d = (in_data == '0);
      case (state_q)
        HUNT: begin
          if (in_data != '0) begin
            expected_d  = nxt(in_data);
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == expected_q) begin
            expected_d  = nxt(in_data);
            match_cnt_d = match_cnt_q + MATCH_W'(1);
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_run_d = '0;
            end
          end else if (in_data != '0) begin
            // Mismatch on a legal word: treat it as a fresh seed.
            expected_d  = nxt(in_data);
            match_cnt_d = '0;
          end else begin
            match_cnt_d = '0;
            state_d     = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: advance from our own prediction, never from the data.
          expected_d = nxt(expected_q);
          if (in_data == expected_q) begin
            miss_run_d = '0;
          end else begin
            err_hit     = 1'b1;
            err_pulse_d = 1'b1;
            miss_run_d  = miss_run_q + MISS_W'(1);
            if (miss_run_q == MISS_W'(UNLOCK_ERRS - 1)) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              miss_run_d  = '0;
              match_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d     = HUNT;
          locked_d    = 1'b0;
          match_cnt_d = '0;
          miss_run_d  = '0;
        end
      endcase
    end

    // Clear takes effect before the increment of the same cycle.
    err_base  = clr_cnt ? '0 : err_cnt_q;
    err_cnt_d = err_base;
    if (err_hit && (err_base != CNT_MAX)) begin
      err_cnt_d = err_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      zero_det_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      zero_det_q  <= zero_det_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign zero_det  = zero_det_q;

`ifdef LFSR_CHK_BITERR_EN
  localparam int POP_W = $clog2(BITWIDTH + 1);
  // One spare bit so a saturating add can detect overflow even when the
  // popcount is wider than the counter.
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [CNT_W-1:0]    bit_err_cnt_q, bit_err_cnt_d;
  logic [CNT_W-1:0]    bit_base;
  logic [BITWIDTH-1:0] bit_diff;
  logic [POP_W-1:0]    bit_pop;
  logic [SUM_W-1:0]    bit_sum;

  always_comb begin
    bit_diff = in_data ^ expected_q;
    bit_pop  = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      bit_pop = bit_pop + POP_W'(bit_diff[i]);
    end
    bit_base      = clr_cnt ? '0 : bit_err_cnt_q;
    bit_sum       = SUM_W'(bit_base) + SUM_W'(bit_pop);
    bit_err_cnt_d = bit_base;
    if (in_valid && (state_q == LOCKED)) begin
      bit_err_cnt_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_err_cnt_q <= '0;
    end else begin
      bit_err_cnt_q <= bit_err_cnt_d;
    end
  end

  assign bit_err_cnt = bit_err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_galois_lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_galois_lfsr_checker                                        |
// | Purpose  : Self-checking bench for galois_lfsr_checker. Two instances    |
// |            (CNT_W=16 and CNT_W=2) see the same stimulus; a behavioural   |
// |            model expressed as "length of the current chain of words that |
// |            each follow the previous one" predicts every output.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_galois_lfsr_checker;

  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_ERRS = 3;

  logic       clk;
  logic       arst_n;
  logic       in_valid;
  logic [4:0] in_data;
  logic       clr_cnt;

  logic        locked_a, err_pulse_a, zero_det_a;
  logic [15:0] err_cnt_a;
  logic        locked_b, err_pulse_b, zero_det_b;
  logic [1:0]  err_cnt_b;
`ifdef LFSR_CHK_BITERR_EN
  logic [15:0] bit_err_cnt_a;
  logic [1:0]  bit_err_cnt_b;
`endif

  galois_lfsr_checker #(.CNT_W(16)) dut_a (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
    .clr_cnt(clr_cnt), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_cnt(err_cnt_a), .zero_det(zero_det_a)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_cnt(bit_err_cnt_a)
`endif
  );

  galois_lfsr_checker #(.CNT_W(2)) dut_b (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
    .clr_cnt(clr_cnt), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_cnt(err_cnt_b), .zero_det(zero_det_b)
`ifdef LFSR_CHK_BITERR_EN
    , .bit_err_cnt(bit_err_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] nxt(input logic [4:0] s);
    return (s >> 1) ^ (s[0] ? 5'b10100 : 5'b00000);
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  // ---------------- behavioural model ----------------
  int         m_chain;   // words in the current self-consistent run (0 = hunting)
  logic [4:0] m_prev;
  logic [4:0] m_fly;
  int         m_miss;
  bit         m_locked, m_err_pulse, m_zero;
  int         m_err16, m_err2, m_bit16, m_bit2;

  task automatic model_reset();
    m_chain = 0; m_prev = '0; m_fly = '0; m_miss = 0;
    m_locked = 0; m_err_pulse = 0; m_zero = 0;
    m_err16 = 0; m_err2 = 0; m_bit16 = 0; m_bit2 = 0;
  endtask

  task automatic model_update(input bit v, input logic [4:0] d, input bit c);
    int pc;
    m_err_pulse = 0;
    m_zero      = 0;
    if (c) begin
      m_err16 = 0; m_err2 = 0; m_bit16 = 0; m_bit2 = 0;
    end
    if (v) begin
      m_zero = (d == 5'd0);
      if (m_locked) begin
        pc = $countones(d ^ m_fly);
        m_bit16 = sat(m_bit16 + pc, 65535);
        m_bit2  = sat(m_bit2 + pc, 3);
        if (d != m_fly) begin
          m_err_pulse = 1;
          m_err16 = sat(m_err16 + 1, 65535);
          m_err2  = sat(m_err2 + 1, 3);
          m_miss++;
          if (m_miss == UNLOCK_ERRS) begin
            m_locked = 0; m_miss = 0; m_chain = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_fly = nxt(m_fly);
      end else if (m_chain > 0 && d == nxt(m_prev)) begin
        m_chain++;
        m_prev = d;
        if (m_chain == LOCK_CNT + 1) begin
          m_locked = 1; m_fly = nxt(d); m_miss = 0;
        end
      end else if (d != 5'd0) begin
        m_chain = 1;
        m_prev  = d;
      end else begin
        m_chain = 0;
      end
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("locked_a",    int'(locked_a),    int'(m_locked));
      chk("err_pulse_a", int'(err_pulse_a), int'(m_err_pulse));
      chk("zero_det_a",  int'(zero_det_a),  int'(m_zero));
      chk("err_cnt_a",   int'(err_cnt_a),   m_err16);
      chk("locked_b",    int'(locked_b),    int'(m_locked));
      chk("err_cnt_b",   int'(err_cnt_b),   m_err2);
`ifdef LFSR_CHK_BITERR_EN
      chk("bit_err_cnt_a", int'(bit_err_cnt_a), m_bit16);
      chk("bit_err_cnt_b", int'(bit_err_cnt_b), m_bit2);
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic step(input bit v, input logic [4:0] d, input bit c);
    in_valid = v; in_data = d; clr_cnt = c;
    @(posedge clk);
    model_update(v, d, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 arst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [4:0] cur;
  logic [4:0] seq0 [5];

  initial begin
    arst_n = 1'b0; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
    model_reset();
    seq0[0] = 5'h01; seq0[1] = 5'h14; seq0[2] = 5'h0A; seq0[3] = 5'h05; seq0[4] = 5'h16;
    repeat (2) @(negedge clk);
    chk("rst_locked",    int'(locked_a),    0);
    chk("rst_err_cnt",   int'(err_cnt_a),   0);
    chk("rst_err_pulse", int'(err_pulse_a), 0);
    chk("rst_zero_det",  int'(zero_det_a),  0);
    #2 arst_n = 1'b1;
    @(negedge clk);

    // Lock on the documented sequence.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq0[i], 1'b0);
      if (i == 3) chk("lock_early", int'(locked_a), 0);
    end
    chk("lock_5th", int'(locked_a), 1);
    chk("lock_err_cnt", int'(err_cnt_a), 0);

    // Zero word in place of 0x0B, then 0x11 must still match.
    step(1'b1, 5'h00, 1'b0);
    chk("zero_det_pulse", int'(zero_det_a), 1);
    chk("zero_err_pulse", int'(err_pulse_a), 1);
    chk("zero_err_cnt", int'(err_cnt_a), 1);
    chk("zero_locked", int'(locked_a), 1);
    step(1'b1, 5'h11, 1'b0);
    chk("fly_err_pulse", int'(err_pulse_a), 0);
    chk("fly_err_cnt", int'(err_cnt_a), 1);
    cur = 5'h11;

    // Three consecutive wrong words drop lock.
    for (int i = 0; i < 3; i++) begin
      cur = nxt(cur);
      step(1'b1, cur ^ 5'h03, 1'b0);
      if (i == 1) chk("unlock_early", int'(locked_a), 1);
    end
    chk("unlock_locked", int'(locked_a), 0);
    chk("unlock_err_cnt", int'(err_cnt_a), 4);
    step(1'b1, 5'h00, 1'b0);
    chk("hunt_zero_det", int'(zero_det_a), 1);
    for (int i = 0; i < 5; i++) begin
      cur = nxt(cur);
      step(1'b1, cur, 1'b0);
      if (i == 3) chk("relock_early", int'(locked_a), 0);
    end
    chk("relock", int'(locked_a), 1);

    // VERIFY reseed: 01, 14, 07 then good continuation from 07.
    do_reset();
    step(1'b1, 5'h01, 1'b0);
    step(1'b1, 5'h14, 1'b0);
    step(1'b1, 5'h07, 1'b0);
    cur = 5'h07;
    for (int i = 0; i < 4; i++) begin
      cur = nxt(cur);
      step(1'b1, cur, 1'b0);
      if (i == 2) chk("reseed_early", int'(locked_a), 0);
    end
    chk("reseed_lock", int'(locked_a), 1);
    chk("reseed_err_cnt", int'(err_cnt_a), 0);

    // Gapped valid: lock timing counts valid samples only.
    do_reset();
    cur = 5'h01;
    step(1'b1, cur, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'h1A, 1'b0);
      cur = nxt(cur);
      step(1'b1, cur, 1'b0);
      if (i == 2) chk("gap_early", int'(locked_a), 0);
    end
    chk("gap_lock", int'(locked_a), 1);
    cur = nxt(cur);
    step(1'b1, cur ^ 5'h01, 1'b0);
    chk("gap_err_cnt", int'(err_cnt_a), 1);
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_locked", int'(locked_a), 0);
    chk("arst_err_cnt", int'(err_cnt_a), 0);
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);

    // 0x1F in place of expected 0x0B: two differing bits.
    for (int i = 0; i < 5; i++) step(1'b1, seq0[i], 1'b0);
    step(1'b1, 5'h1F, 1'b0);
    chk("biterr_err_cnt", int'(err_cnt_a), 1);
`ifdef LFSR_CHK_BITERR_EN
    chk("biterr_bits", int'(bit_err_cnt_a), 2);
`endif
    cur = 5'h0B;

    // Saturation of the 2-bit counter, then clear-with-error.
    for (int i = 0; i < 4; i++) begin
      cur = nxt(cur);
      step(1'b1, cur ^ 5'h01, 1'b0);
      cur = nxt(cur);
      step(1'b1, cur, 1'b0);
    end
    chk("sat_b", int'(err_cnt_b), 3);
    chk("sat_a", int'(err_cnt_a), 5);
    cur = nxt(cur);
    step(1'b1, cur ^ 5'h01, 1'b1);
    chk("clr_err_b", int'(err_cnt_b), 1);
    chk("clr_err_a", int'(err_cnt_a), 1);
    step(1'b0, 5'h00, 1'b1);
    chk("clr_alone", int'(err_cnt_a), 0);

    // Randomised traffic: a transmitter walking the sequence with noise.
    do_reset();
    cur = 5'h01;
    begin
      int burst;
      burst = 0;
      for (int n = 0; n < 4000; n++) begin
        bit         v, c;
        logic [4:0] d;
        int         r;
        v = ($urandom_range(0, 99) < 85);
        c = ($urandom_range(0, 199) == 0);
        d = 5'h00;
        if (v) begin
          cur = nxt(cur);
          d   = cur;
          r   = $urandom_range(0, 999);
          if (burst == 0 && r < 4) burst = 3;
          if (burst > 0) begin
            d = cur ^ 5'($urandom_range(1, 31));
            burst--;
          end else if (r < 40) begin
            d = 5'($urandom_range(0, 31));
          end else if (r < 50) begin
            d = 5'h00;
          end else if (r < 55) begin
            cur = 5'($urandom_range(1, 31));
            d   = cur;
          end
        end else begin
          d = 5'($urandom_range(0, 31));
        end
        step(v, d, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
